// File: rtl/dds_gen_if.sv
// Interface bundle for dds_gen: control/parameter handshake plus sample stream.
// master = the block driving controls and parameters, slave = dds_gen itself.
interface dds_gen_if #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned OUT_W   = 8
);
    logic               enable;
    logic [PHASE_W-1:0] phase_step;
    logic [7:0]         amplitude;
    logic [1:0]         wave_sel;
    logic               param_valid;
    logic               param_ready;
    logic [OUT_W-1:0]   sample_out;
    logic               sample_valid;
    logic               phase_wrap;

    modport master (
        output enable, phase_step, amplitude, wave_sel, param_valid,
        input  param_ready, sample_out, sample_valid, phase_wrap
    );

    modport slave (
        input  enable, phase_step, amplitude, wave_sel, param_valid,
        output param_ready, sample_out, sample_valid, phase_wrap
    );
endinterface

// File: rtl/dds_gen.sv
// dds_gen: phase-accumulator waveform generator (sine/square/triangle/saw)
// with amplitude scaling and an offset-binary 8-bit output.
// Pipeline: acc -> waveform -> product -> sample_out (3 cycles after acc).
// Optional macro DDS_SYNC_UPDATE_EN: a pending parameter set is applied on the
// accumulator carry (or at once while disabled) instead of the cycle after
// acceptance, so frequency changes land on a period boundary.
module dds_gen #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned OUT_W   = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    dds_gen_if.slave bus
);

    localparam logic [PHASE_W-1:0] RST_STEP    = PHASE_W'(10000);
    localparam logic [7:0]         RST_AMP     = 8'd255;
    localparam logic [OUT_W-1:0]   MID         = OUT_W'(128);
    localparam logic signed [7:0]  W_POS       = 8'sd127;
    localparam logic signed [7:0]  W_NEG       = -8'sd127;
    localparam logic signed [7:0]  W_LOW       = -8'sd128;
    localparam longint             HALF_PI_Q30 = 64'sd1686629713;

    // Quarter-wave entry round(127*sin(pi/2*(idx+0.5)/256)), Q30 Taylor series
    // evaluated at elaboration so the table is a constant ROM.
    function automatic logic [6:0] sine_entry(input int unsigned idx);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (HALF_PI_Q30 * longint'(2 * idx + 1)) / 64'sd512;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int unsigned k = 1; k <= 7; k++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
            sum  = sum + term;
        end
        return 7'((sum * 64'sd127 + (64'sd1 <<< 29)) >>> 30);
    endfunction

    typedef enum logic [1:0] {UPD_IDLE, UPD_PEND, UPD_COOL} upd_state_t;

    upd_state_t          upd_state;
    upd_state_t          upd_next;
    logic                param_ready;
    logic                accept;
    logic                apply;

    logic [PHASE_W-1:0]  pend_step;
    logic [7:0]          pend_amp;
    logic [PHASE_W-1:0]  active_step;
    logic [7:0]          active_amp;

    logic [PHASE_W-1:0]  acc;
    logic [PHASE_W:0]    acc_sum;
    logic                wrap_r;
    logic [2:0]          en_pipe;

    logic [6:0]          sine_rom [256];
    logic [9:0]          phase_idx;
    logic [7:0]          rom_addr;
    logic signed [7:0]   rom_mag;
    logic signed [7:0]   sine_w;
    logic [7:0]          tri_t;
    logic signed [7:0]   tri_w;
    logic signed [7:0]   saw_w;
    logic signed [7:0]   wave_next;

    logic signed [7:0]   wave_r;
    logic signed [15:0]  prod_r;
    logic [OUT_W-1:0]    sample_r;

    for (genvar g = 0; g < 256; g++) begin : g_sine_rom
        localparam logic [6:0] ENTRY = sine_entry(g);
        assign sine_rom[g] = ENTRY;
    end

    assign acc_sum   = {1'b0, acc} + {1'b0, active_step};
    assign phase_idx = acc[PHASE_W-1 -: 10];

    // Parameter-update FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) upd_state <= UPD_IDLE;
        else          upd_state <= upd_next;
    end

    // Next state: accept -> pending -> one cool-down cycle -> idle.
    always_comb begin
        upd_next = upd_state;
        case (upd_state)
            UPD_IDLE: if (bus.param_valid) upd_next = UPD_PEND;
            UPD_PEND: if (apply)           upd_next = UPD_COOL;
            UPD_COOL:                      upd_next = UPD_IDLE;
            default:                       upd_next = UPD_IDLE;
        endcase
    end

    // FSM outputs: ready only when idle; when a pending set gets applied.
    always_comb begin
        param_ready = (upd_state == UPD_IDLE);
        accept      = param_ready && bus.param_valid;
`ifdef DDS_SYNC_UPDATE_EN
        apply       = (upd_state == UPD_PEND) && (!bus.enable || acc_sum[PHASE_W]);
`else
        apply       = (upd_state == UPD_PEND);
`endif
    end

    // Pending and active parameter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_step   <= RST_STEP;
            pend_amp    <= RST_AMP;
            active_step <= RST_STEP;
            active_amp  <= RST_AMP;
        end else begin
            if (accept) begin
                pend_step <= bus.phase_step;
                pend_amp  <= bus.amplitude;
            end
            if (apply) begin
                active_step <= pend_step;
                active_amp  <= pend_amp;
            end
        end
    end

    // Phase accumulator, carry pulse and enable delay line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            wrap_r  <= 1'b0;
            en_pipe <= '0;
        end else begin
            if (bus.enable) acc <= acc_sum[PHASE_W-1:0];
            wrap_r  <= bus.enable && acc_sum[PHASE_W];
            en_pipe <= {en_pipe[1:0], bus.enable};
        end
    end

    // Waveform shapes from the current accumulator value, selected by wave_sel.
    always_comb begin
        rom_addr = phase_idx[8] ? ~phase_idx[7:0] : phase_idx[7:0];
        rom_mag  = $signed({1'b0, sine_rom[rom_addr]});
        sine_w   = phase_idx[9] ? -rom_mag : rom_mag;

        tri_t = acc[PHASE_W-1] ? ~acc[PHASE_W-2 -: 8] : acc[PHASE_W-2 -: 8];
        // Flipping the MSB of an unsigned byte is the same as subtracting 128.
        tri_w = $signed({~tri_t[7], tri_t[6:0]});
        if (tri_w == W_LOW) tri_w = W_NEG;

        saw_w = $signed({~acc[PHASE_W-1], acc[PHASE_W-2 -: 7]});
        if (saw_w == W_LOW) saw_w = W_NEG;

        case (bus.wave_sel)
            2'd0:    wave_next = sine_w;
            2'd1:    wave_next = acc[PHASE_W-1] ? W_NEG : W_POS;
            2'd2:    wave_next = tri_w;
            default: wave_next = saw_w;
        endcase
    end

    // Output pipeline: waveform, scaled product, offset-binary sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wave_r   <= '0;
            prod_r   <= '0;
            sample_r <= MID;
        end else begin
            wave_r   <= wave_next;
            prod_r   <= 16'(wave_r) * 16'($signed({1'b0, active_amp}));
            sample_r <= OUT_W'(prod_r >>> 8) + MID;
        end
    end

    assign bus.param_ready  = param_ready;
    assign bus.sample_out   = sample_r;
    assign bus.sample_valid = en_pipe[2];
    assign bus.phase_wrap   = wrap_r;

endmodule

// File: doc/dds_gen.md
DDS_GEN -- requirements
Module: dds_gen

Interface
REQ-001 The block SHALL have the parameter PHASE_W, default 32, meaning phase accumulator and phase_step width.
REQ-002 The block SHALL have the parameter OUT_W, default 8, meaning the sample_out width; only 8 is supported.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, listed first among the ports below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  accumulator advance enable.
REQ-007 phase_step  in  PHASE_W  requested phase increment per cycle, unsigned.
REQ-008 amplitude  in  8  requested amplitude, unsigned, 255 = full scale.
REQ-009 wave_sel  in  2  waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-010 param_valid  in  1  phase_step and amplitude are valid to load.
REQ-011 param_ready  out  1  block can accept a new parameter set.
REQ-012 sample_out  out  8  offset-binary sample, 128 = zero.
REQ-013 sample_valid  out  1  sample_out is driven from an enabled accumulator value.
REQ-014 phase_wrap  out  1  one-cycle pulse on accumulator carry-out.

Function
REQ-015 A parameter set SHALL be accepted into pending registers on any cycle with param_valid=1 and param_ready=1.
REQ-016 param_ready SHALL be 0 from the cycle after acceptance until the cycle after the pending set is applied.
REQ-017 Applying a pending set SHALL copy it into the active step and active amplitude registers.
REQ-018 Each cycle with enable=1, acc SHALL be updated to acc + active_step modulo 2^PHASE_W.
REQ-019 When that addition produces a carry, phase_wrap SHALL be 1 in the following cycle; otherwise phase_wrap SHALL be 0.
REQ-020 With enable=0, acc SHALL hold its value and phase_wrap SHALL be 0.
REQ-021 Let p = acc[PHASE_W-1:PHASE_W-10]; then q = p[9:8] and a = p[7:0].
REQ-022 Sine SHALL use a 256-entry quarter-wave ROM holding round(127*sin(pi/2*(i+0.5)/256)).
REQ-023 The sine ROM address SHALL be a for q=0 or 2 and ~a for q=1 or 3, and the ROM value SHALL be negated for q=2 or 3.
REQ-024 Square SHALL be +127 when the acc MSB is 0, and -127 otherwise.
REQ-025 Triangle SHALL be t-128 clamped to -127, where t = acc[PHASE_W-2:PHASE_W-9], bitwise inverted when the MSB is 1.
REQ-026 Sawtooth SHALL be acc[PHASE_W-1:PHASE_W-8]-128 clamped to -127.
REQ-027 The waveform value w SHALL be signed, in the range -127..127.
REQ-028 Scaling SHALL compute prod = w*amplitude as 16-bit signed and sample = (prod >>> 8) + 128, arithmetic shift, no rounding.
REQ-029 The pipeline SHALL be acc register -> waveform register -> product register -> sample_out register.
REQ-030 sample_out SHALL reflect an acc value exactly 3 cycles after that acc value is registered.
REQ-031 sample_valid SHALL equal enable delayed by 3 cycles.
REQ-032 wave_sel SHALL be sampled at the waveform stage, and a change mid-period SHALL take effect immediately with no phase reset.
REQ-033 The pipeline SHALL advance every cycle regardless of enable.
REQ-034 A param_valid asserted while param_ready=0 SHALL be ignored, with no overwrite of the pending set.

Reset
REQ-035 While reset_n=0, acc SHALL be 0.
REQ-036 While reset_n=0, active and pending step SHALL be 10000 and active and pending amplitude SHALL be 255.
REQ-037 While reset_n=0, the pending flag SHALL be clear and param_ready SHALL be 1.
REQ-038 While reset_n=0, sample_out SHALL be 128, sample_valid 0 and phase_wrap 0.
REQ-039 All pipeline registers SHALL be cleared to produce sample 128.
REQ-040 Reset asserted mid-operation SHALL discard any pending set and restart from acc=0 on the first enabled cycle after release.

Configuration
REQ-041 Macro DDS_SYNC_UPDATE_EN defined: a pending set SHALL apply in the cycle the accumulator carry occurs, with the new step used from the next addition.
REQ-042 Macro DDS_SYNC_UPDATE_EN defined: with enable=0, a pending set SHALL apply on the cycle after acceptance.
REQ-043 Macro DDS_SYNC_UPDATE_EN undefined: a pending set SHALL always apply on the cycle after acceptance, giving 2-cycle param_ready low per accept.

Verification
REQ-044 Reset release, enable=1, step 10000, amp 255 -> first sample_valid=1 on cycle 3, acc increments by 10000 per cycle, phase_wrap first at cycle 429497.
REQ-045 Sine, amp 255, step 2^22 -> sample_out peaks at 254 and troughs at 1; amp 0 -> constant 128.
REQ-046 Square, amp 128, step 2^30 -> sample_out alternates 191 (2 samples) and 64 (2 samples).
REQ-047 With DDS_SYNC_UPDATE_EN, step 2^28, load step 2^29 mid-period -> param_ready stays 0 until the wrap; the increment changes only after phase_wrap; the second load during pending is ignored.
REQ-048 enable toggled 1->0->1 -> acc holds, sample_valid falls 3 cycles later, no phase_wrap while disabled.
REQ-049 Assert reset_n=0 with a pending set -> param_ready=1 and step 10000 after release.
